// File: rtl/divider.sv
// IEEE-754 single-precision divider (z = a / b) using iterative restoring long division,
// round-to-nearest-even, with subnormal support and a STB/BUSY handshake on both sides.
module divider #(
  parameter int DEBUG_STATENAME = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic [31:0] input_b,
  input  logic        div_input_STB,
  output logic        div_BUSY,
  output logic [31:0] output_div,
  output logic        div_output_STB,
  input  logic        output_module_BUSY
);

  localparam logic [4:0] GET_A_AND_B   = 5'd0;
  localparam logic [4:0] UNPACK        = 5'd1;
  localparam logic [4:0] SPECIAL_CASES = 5'd2;
  localparam logic [4:0] NORMALISE_A   = 5'd3;
  localparam logic [4:0] NORMALISE_B   = 5'd4;
  localparam logic [4:0] DIVIDE_0      = 5'd5;
  localparam logic [4:0] DIVIDE_1      = 5'd6;
  localparam logic [4:0] DIVIDE_2      = 5'd7;
  localparam logic [4:0] DIVIDE_3      = 5'd8;
  localparam logic [4:0] NORMALISE_1   = 5'd9;
  localparam logic [4:0] NORMALISE_2   = 5'd10;
  localparam logic [4:0] ROUND         = 5'd11;
  localparam logic [4:0] PACK          = 5'd12;
  localparam logic [4:0] PUT_Z         = 5'd13;

  logic [4:0]         state_r;
  logic [31:0]        a_r, b_r, z_r, out_r;
  logic [23:0]        a_m_r, b_m_r, z_m_r;
  logic signed [9:0]  a_e_r, b_e_r, z_e_r;
  logic               a_s_r, b_s_r, z_s_r;
  logic               guard_r, round_bit_r, sticky_r;
  logic [50:0]        quotient_r, remainder_r, dividend_r;
  logic [5:0]         count_r;
  logic               busy_r, stb_r;

  logic a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;

  // Exponent 128 is the all-ones field; -127 is the all-zeros field.
  assign a_nan_s  = (a_e_r == 10'sd128) && (a_m_r != 24'd0);
  assign b_nan_s  = (b_e_r == 10'sd128) && (b_m_r != 24'd0);
  assign a_inf_s  = (a_e_r == 10'sd128) && (a_m_r == 24'd0);
  assign b_inf_s  = (b_e_r == 10'sd128) && (b_m_r == 24'd0);
  assign a_zero_s = (a_e_r == -10'sd127) && (a_m_r == 24'd0);
  assign b_zero_s = (b_e_r == -10'sd127) && (b_m_r == 24'd0);

  assign div_BUSY       = busy_r;
  assign div_output_STB = stb_r;
  assign output_div     = out_r;

  // Main sequencer: handshakes, unpacking, long division, rounding and packing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= GET_A_AND_B;
      a_r         <= 32'd0;
      b_r         <= 32'd0;
      z_r         <= 32'd0;
      out_r       <= 32'd0;
      a_m_r       <= 24'd0;
      b_m_r       <= 24'd0;
      z_m_r       <= 24'd0;
      a_e_r       <= 10'sd0;
      b_e_r       <= 10'sd0;
      z_e_r       <= 10'sd0;
      a_s_r       <= 1'b0;
      b_s_r       <= 1'b0;
      z_s_r       <= 1'b0;
      guard_r     <= 1'b0;
      round_bit_r <= 1'b0;
      sticky_r    <= 1'b0;
      quotient_r  <= 51'd0;
      remainder_r <= 51'd0;
      dividend_r  <= 51'd0;
      count_r     <= 6'd0;
      busy_r      <= 1'b0;
      stb_r       <= 1'b0;
    end else begin
      case (state_r)
        GET_A_AND_B: begin
          if (div_input_STB && !busy_r) begin
            a_r     <= input_a;
            b_r     <= input_b;
            busy_r  <= 1'b1;
            state_r <= UNPACK;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        UNPACK: begin
          a_m_r   <= {1'b0, a_r[22:0]};
          b_m_r   <= {1'b0, b_r[22:0]};
          a_e_r   <= $signed({2'b00, a_r[30:23]}) - 10'sd127;
          b_e_r   <= $signed({2'b00, b_r[30:23]}) - 10'sd127;
          a_s_r   <= a_r[31];
          b_s_r   <= b_r[31];
          state_r <= SPECIAL_CASES;
        end
        SPECIAL_CASES: begin
          if (a_nan_s || b_nan_s) begin
            z_r     <= 32'hFFC0_0000;
            state_r <= PUT_Z;
          end else if (a_inf_s && b_inf_s) begin
            z_r     <= 32'hFFC0_0000;
            state_r <= PUT_Z;
          end else if (a_inf_s) begin
            z_r     <= {a_s_r ^ b_s_r, 8'hFF, 23'd0};
            state_r <= PUT_Z;
          end else if (b_inf_s) begin
            z_r     <= {a_s_r ^ b_s_r, 31'd0};
            state_r <= PUT_Z;
          end else if (a_zero_s && b_zero_s) begin
            z_r     <= 32'hFFC0_0000;
            state_r <= PUT_Z;
          end else if (b_zero_s) begin
            z_r     <= {a_s_r ^ b_s_r, 8'hFF, 23'd0};
            state_r <= PUT_Z;
          end else if (a_zero_s) begin
            z_r     <= {a_s_r ^ b_s_r, 31'd0};
            state_r <= PUT_Z;
          end else begin
            // Subnormals keep the minimum exponent and no hidden bit.
            if (a_e_r == -10'sd127) begin
              a_e_r <= -10'sd126;
            end else begin
              a_m_r[23] <= 1'b1;
            end
            if (b_e_r == -10'sd127) begin
              b_e_r <= -10'sd126;
            end else begin
              b_m_r[23] <= 1'b1;
            end
            state_r <= NORMALISE_A;
          end
        end
        NORMALISE_A: begin
          if (a_m_r[23]) begin
            state_r <= NORMALISE_B;
          end else begin
            a_m_r <= {a_m_r[22:0], 1'b0};
            a_e_r <= a_e_r - 10'sd1;
          end
        end
        NORMALISE_B: begin
          if (b_m_r[23]) begin
            state_r <= DIVIDE_0;
          end else begin
            b_m_r <= {b_m_r[22:0], 1'b0};
            b_e_r <= b_e_r - 10'sd1;
          end
        end
        DIVIDE_0: begin
          z_s_r       <= a_s_r ^ b_s_r;
          z_e_r       <= a_e_r - b_e_r;
          dividend_r  <= {a_m_r, 27'd0};
          quotient_r  <= 51'd0;
          remainder_r <= 51'd0;
          count_r     <= 6'd0;
          state_r     <= DIVIDE_1;
        end
        DIVIDE_1: begin
          quotient_r  <= {quotient_r[49:0], 1'b0};
          remainder_r <= {remainder_r[49:0], dividend_r[50]};
          dividend_r  <= {dividend_r[49:0], 1'b0};
          state_r     <= DIVIDE_2;
        end
        DIVIDE_2: begin
          if (remainder_r >= {27'd0, b_m_r}) begin
            quotient_r[0] <= 1'b1;
            remainder_r   <= remainder_r - {27'd0, b_m_r};
          end else begin
            quotient_r[0] <= quotient_r[0];
          end
          if (count_r == 6'd49) begin
            state_r <= DIVIDE_3;
          end else begin
            count_r <= count_r + 6'd1;
            state_r <= DIVIDE_1;
          end
        end
        DIVIDE_3: begin
          z_m_r       <= quotient_r[26:3];
          guard_r     <= quotient_r[2];
          round_bit_r <= quotient_r[1];
          sticky_r    <= quotient_r[0] | (remainder_r != 51'd0);
          state_r     <= NORMALISE_1;
        end
        NORMALISE_1: begin
          if (!z_m_r[23] && (z_e_r > -10'sd126)) begin
            z_m_r       <= {z_m_r[22:0], guard_r};
            guard_r     <= round_bit_r;
            round_bit_r <= 1'b0;
            z_e_r       <= z_e_r - 10'sd1;
          end else begin
            state_r <= NORMALISE_2;
          end
        end
        NORMALISE_2: begin
          if (z_e_r < -10'sd126) begin
            z_m_r       <= {1'b0, z_m_r[23:1]};
            z_e_r       <= z_e_r + 10'sd1;
            sticky_r    <= sticky_r | round_bit_r;
            round_bit_r <= guard_r;
            guard_r     <= z_m_r[0];
          end else begin
            state_r <= ROUND;
          end
        end
        ROUND: begin
          if (guard_r && (round_bit_r || sticky_r || z_m_r[0])) begin
            z_m_r <= z_m_r + 24'd1;
            if (z_m_r == 24'hFF_FFFF) begin
              z_e_r <= z_e_r + 10'sd1;
            end else begin
              z_e_r <= z_e_r;
            end
          end else begin
            z_m_r <= z_m_r;
          end
          state_r <= PACK;
        end
        PACK: begin
          if (z_e_r > 10'sd127) begin
            z_r <= {z_s_r, 8'hFF, 23'd0};
          end else if ((z_e_r == -10'sd126) && !z_m_r[23]) begin
            z_r <= {z_s_r, 8'd0, z_m_r[22:0]};
          end else begin
            z_r <= {z_s_r, z_e_r[7:0] + 8'd127, z_m_r[22:0]};
          end
          state_r <= PUT_Z;
        end
        PUT_Z: begin
          // BUSY drops on the transfer edge so the next operand can land one cycle later.
          if (!stb_r) begin
            stb_r <= 1'b1;
            out_r <= z_r;
          end else if (!output_module_BUSY) begin
            stb_r   <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= GET_A_AND_B;
          end else begin
            stb_r <= 1'b1;
          end
        end
        default: begin
          state_r <= GET_A_AND_B;
          busy_r  <= 1'b0;
          stb_r   <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (DEBUG_STATENAME != 0) begin : g_state_name
      logic [8*13-1:0] state_name_r;
      // Human-readable copy of the current state for waveform viewing.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_name_r <= "get_a_and_b";
        end else begin
          case (state_r)
            GET_A_AND_B:   state_name_r <= "get_a_and_b";
            UNPACK:        state_name_r <= "unpack";
            SPECIAL_CASES: state_name_r <= "special_cases";
            NORMALISE_A:   state_name_r <= "normalise_a";
            NORMALISE_B:   state_name_r <= "normalise_b";
            DIVIDE_0:      state_name_r <= "divide_0";
            DIVIDE_1:      state_name_r <= "divide_1";
            DIVIDE_2:      state_name_r <= "divide_2";
            DIVIDE_3:      state_name_r <= "divide_3";
            NORMALISE_1:   state_name_r <= "normalise_1";
            NORMALISE_2:   state_name_r <= "normalise_2";
            ROUND:         state_name_r <= "round";
            PACK:          state_name_r <= "pack";
            PUT_Z:         state_name_r <= "put_z";
            default:       state_name_r <= "unknown";
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vectors, handshake/reset scenarios and
// randomized operands checked against an exact-arithmetic IEEE-754 division model.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic [31:0] input_b;
  logic        div_input_STB;
  logic        div_BUSY;
  logic [31:0] output_div;
  logic        div_output_STB;
  logic        output_module_BUSY;

  int checks   = 0;
  int failures = 0;

  divider dut (
    .clk                (clk),
    .rst                (rst),
    .input_a            (input_a),
    .input_b            (input_b),
    .div_input_STB      (div_input_STB),
    .div_BUSY           (div_BUSY),
    .output_div         (output_div),
    .div_output_STB     (div_output_STB),
    .output_module_BUSY (output_module_BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Correctly rounded (nearest-even) quotient computed with wide integer arithmetic.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic         s;
    logic [7:0]   xa, xb;
    logic [22:0]  fa, fb;
    logic [23:0]  ma, mb;
    logic [127:0] num, q, r, rem_lo, half;
    logic [63:0]  m, mag;
    int           ea, eb, p, e_top, lsb, sh;
    bit           up;
    s  = a[31] ^ b[31];
    xa = a[30:23]; xb = b[30:23];
    fa = a[22:0];  fb = b[22:0];
    if ((xa == 8'hFF && fa != 23'd0) || (xb == 8'hFF && fb != 23'd0)) return 32'hFFC0_0000;
    if (xa == 8'hFF && xb == 8'hFF) return 32'hFFC0_0000;
    if (xa == 8'hFF) return {s, 8'hFF, 23'd0};
    if (xb == 8'hFF) return {s, 31'd0};
    if (xa == 8'd0 && fa == 23'd0 && xb == 8'd0 && fb == 23'd0) return 32'hFFC0_0000;
    if (xb == 8'd0 && fb == 23'd0) return {s, 8'hFF, 23'd0};
    if (xa == 8'd0 && fa == 23'd0) return {s, 31'd0};
    ma = (xa != 8'd0) ? {1'b1, fa} : {1'b0, fa};
    mb = (xb != 8'd0) ? {1'b1, fb} : {1'b0, fb};
    ea = (xa != 8'd0) ? int'(xa) - 127 : -126;
    eb = (xb != 8'd0) ? int'(xb) - 127 : -126;
    // value = q * 2^(ea-eb-60) + (r/mb) * 2^(ea-eb-60)
    num = {104'd0, ma} << 60;
    q   = num / {104'd0, mb};
    r   = num % {104'd0, mb};
    p = 0;
    for (int i = 0; i < 128; i++) if (q[i]) p = i;
    e_top = p + ea - eb - 60;
    lsb   = (e_top >= -126) ? e_top - 23 : -149;
    sh    = lsb - (ea - eb - 60);
    if (sh > 120) return {s, 31'd0};
    m      = 64'(q >> sh);
    rem_lo = q & ((128'd1 << sh) - 128'd1);
    half   = 128'd1 << (sh - 1);
    up     = (rem_lo > half) || (rem_lo == half && (r != 128'd0 || m[0]));
    mag    = (64'(lsb + 149) << 23) + m + (up ? 64'd1 : 64'd0);
    if (mag >= 64'h7F80_0000) return {s, 8'hFF, 23'd0};
    return {s, mag[30:0]};
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    while (div_BUSY && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_timeout"}, 32'(n >= 1000), 32'd0);
  endtask

  // Issue one operation, hold the consumer busy for 'hold' cycles, check result and handshake.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] expv,
                       input int hold, input string tag);
    int n;
    logic [31:0] held;
    wait_idle(tag);
    output_module_BUSY = (hold > 0);
    input_a = a;
    input_b = b;
    div_input_STB = 1'b1;
    @(negedge clk);
    div_input_STB = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(div_BUSY), 32'd1);
    n = 0;
    while (!div_output_STB && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_result_timeout"}, 32'(n >= 1000), 32'd0);
    check({tag, "_result"}, output_div, expv);
    held = output_div;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_stb"}, 32'(div_output_STB), 32'd1);
      check({tag, "_hold_data"}, output_div, held);
      check({tag, "_hold_busy"}, 32'(div_BUSY), 32'd1);
    end
    output_module_BUSY = 1'b0;
    @(negedge clk);
    check({tag, "_stb_cleared"}, 32'(div_output_STB), 32'd0);
    check({tag, "_busy_cleared"}, 32'(div_BUSY), 32'd0);
    check({tag, "_data_kept"}, output_div, held);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int sel;
    rst = 1'b0;
    input_a = 32'd0;
    input_b = 32'd0;
    div_input_STB = 1'b0;
    output_module_BUSY = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(div_BUSY), 32'd0);
    check("reset_stb", 32'(div_output_STB), 32'd0);
    check("reset_out", output_div, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, "six_div_two");
    repeat (5) @(negedge clk);
    check("six_div_two_no_second_stb", 32'(div_output_STB), 32'd0);
    do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 0, "one_third");
    do_op(32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0, "div_by_zero");
    do_op(32'h0000_0000, 32'h0000_0000, 32'hFFC0_0000, 0, "zero_zero");
    do_op(32'h7FC0_0000, 32'h3F80_0000, 32'hFFC0_0000, 0, "nan_in");
    do_op(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 0, "overflow");
    do_op(32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 0, "subnormal_out");
    do_op(32'h0000_0001, 32'h3F00_0000, 32'h0000_0002, 0, "subnormal_in");
    do_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 5, "consumer_busy");

    // Abort in the middle of the divide loop.
    wait_idle("abort");
    input_a = 32'h40C0_0000;
    input_b = 32'h4000_0000;
    div_input_STB = 1'b1;
    @(negedge clk);
    div_input_STB = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(div_BUSY), 32'd0);
    check("abort_stb", 32'(div_output_STB), 32'd0);
    check("abort_out", output_div, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, "after_abort");

    for (int k = 0; k < 200; k++) begin
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: ra[30:23] = 8'd0;
        1: begin ra[30:23] = 8'($urandom_range(1, 20));   rb[30:23] = 8'($urandom_range(150, 254)); end
        2: begin ra[30:23] = 8'($urandom_range(230, 254)); rb[30:23] = 8'($urandom_range(1, 30)); end
        3: rb[22:0] = 23'd0;
        4: begin ra[30:23] = 8'($urandom_range(110, 140)); rb[30:23] = 8'($urandom_range(110, 140)); end
        default: ;
      endcase
      do_op(ra, rb, ref_div(ra, rb), (k % 10 == 0) ? 2 : 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
